uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
8N1 UART transceiver with an independent transmit path and receive path sharing one clock. The transmitter serialises a byte on a one-cycle start request and reports busy. The receiver oversamples the rx line, deserialises a frame, and reports the byte with a one-cycle done pulse. The block sits between a byte-wide core interface and the serial pins; the test bench connects tx to rx for loopback.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; even integer, minimum 4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
tx_start  input  1  one-cycle request to send tx_data.
tx_data  input  8  byte to send; sampled only in the accept cycle.
tx  output  1  serial output; idles high.
tx_busy  output  1  high while a frame is in progress.
rx  input  1  serial input; asynchronous to clk.
rx_data  output  8  last correctly framed byte; held until the next good frame.
rx_done  output  1  one-cycle pulse when rx_data updates.
rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (clk edge with rst=1): tx=1, tx_busy=0, rx_data=0, rx_done=0, rx_frame_err=0. Both FSMs go to IDLE; rx synchroniser flops are set to 1. Reset mid-frame aborts immediately with no partial output.
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. No parity.
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE with tx_start=1, the block latches tx_data. On the next cycle tx_busy=1 and tx=0.
  - Each bit is driven for exactly CLKS_PER_BIT cycles. The full frame lasts 10*CLKS_PER_BIT cycles.
  - After the stop bit, the FSM returns to IDLE: tx_busy=0 and tx=1.
  - A new start can be accepted in the first cycle tx_busy=0.
  - tx_start while tx_busy=1 is ignored, not queued.
- RX input: rx passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised low level moves the FSM to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If the line is high, it was a glitch: return to IDLE with no outputs. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit and shift in LSB first, 8 bits.
  - STOP: sample at mid-bit.
    - Sample=1: wait a further CLKS_PER_BIT/2 cycles. Then load rx_data, pulse rx_done for 1 cycle, and return to IDLE.
    - Sample=0: pulse rx_frame_err for 1 cycle, leave rx_data unchanged, and return to IDLE after the same wait.
  - Because rx_done follows the end of the stop bit, tx_busy is already low when rx_done fires in loopback.
  - IDLE detects start on level, so back-to-back frames with no idle gap are received.
- Loopback latency: rx_done asserts about 10*CLKS_PER_BIT + 3 cycles after the tx_start accept cycle. Tolerance is ±2 cycles.
- rx_done and rx_frame_err are never high in the same cycle.
- Counters are sized $clog2(CLKS_PER_BIT) bits; bit index is 3 bits. No wrap-around beyond these states.

Decomposition:
- Shared package uart_pkg holds:
  - the state enums for TX and RX;
  - the constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module is natural: uart_rx_path (synchroniser, RX FSM, sampling counter), instantiated by uart_txrx.
- The TX FSM stays inline in uart_txrx.

Test Plan:
- Reset:
  - assert rst 3 cycles → tx=1, tx_busy=0, rx_done=0, rx_frame_err=0, rx_data=0x00.
- Loopback 0x41 (tx tied to rx):
  - one-cycle tx_start → tx shows bit sequence 0,1,0,0,0,0,0,1,0,1, each held CLKS_PER_BIT cycles.
  - tx_busy is high for 10*CLKS_PER_BIT cycles.
  - rx_done pulses once; rx_data=0x41 and holds afterwards.
- Second byte 0x42, started 6 cycles after the first rx_done → accepted; rx_done pulses; rx_data=0x42.
- tx_start pulsed with data 0x55 while busy sending 0x41 → ignored. Only 0x41 is transmitted and received, and tx_busy timing is unchanged.
- Framing error: drive rx directly with 0x3C and stop bit=0 → rx_frame_err pulses once, no rx_done, rx_data keeps its prior value. A following valid 0xA5 frame is received correctly.
- Glitch and reset:
  - rx low for CLKS_PER_BIT/2-2 cycles → no rx_done and no rx_frame_err.
  - rst asserted mid-DATA on TX → next cycle tx=1, tx_busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and framing constants for the uart_txrx transceiver.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_path.sv
// Receive path: 2-flop synchroniser, mid-bit sampling FSM and result registers.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_done_o,
  output logic                 rx_frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 sampled_q, sampled_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      sampled_q <= 1'b0;
      stop_ok_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      sampled_q <= sampled_d;
      stop_ok_q <= stop_ok_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    sampled_d = sampled_q;
    stop_ok_d = stop_ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_s == START_BIT) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = RX_STOP;
            sampled_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Sample the stop bit at mid-bit, then ride out its second half before reporting.
        if (!sampled_q) begin
          if (cnt_q == BIT_LAST) begin
            sampled_d = 1'b1;
            stop_ok_d = (rx_s == STOP_BIT);
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == HALF_LAST) begin
          state_d   = RX_IDLE;
          sampled_d = 1'b0;
          cnt_d     = '0;
          if (stop_ok_q) begin
            data_d = shreg_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data_o      = data_q;
  assign rx_done_o      = done_q;
  assign rx_frame_err_o = err_q;

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART transceiver: inline transmit FSM plus the uart_rx_path receiver.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Line level and busy are derived from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          data_d  = tx_data;
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    tx_d = STOP_BIT;
    case (state_d)
      TX_START: tx_d = START_BIT;
      TX_DATA:  tx_d = data_d[bit_idx_d];
      default:  tx_d = STOP_BIT;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

  uart_rx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_path (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_i          (rx),
    .rx_data_o     (rx_data),
    .rx_done_o     (rx_done),
    .rx_frame_err_o(rx_frame_err)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed loopback and direct-drive bench for uart_txrx.
module tb_uart_txrx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, rx;
  logic [7:0] rx_data;
  logic       rx_done, rx_frame_err;
  logic       loopback = 1'b1;
  logic       rx_drv = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int accept_cyc = 0;
  int base_done, base_err, lat;
  bit both_seen = 1'b0;

  assign rx = loopback ? tx : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled on the falling edge, away from the DUT update.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (rx_frame_err) err_cnt = err_cnt + 1;
    if (rx_done && rx_frame_err) both_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle tx_start request; returns at the falling edge just after the accept edge.
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    accept_cyc = cyc;
  endtask

  // Check each bit's first and last cycle on tx, and busy over exactly one frame.
  task automatic sendAndCheckFrame(input logic [7:0] d, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    applyStimulus(d);
    for (int i = 0; i < FRAME; i++) begin
      if (inject && i == 2 * CPB) begin
        tx_start = 1'b1;
        tx_data  = 8'h55;
      end else begin
        tx_start = 1'b0;
      end
      if ((i % CPB) == 0 || (i % CPB) == CPB - 1) begin
        checkOutput($sformatf("tx bit%0d cyc%0d", i / CPB, i), {31'd0, tx}, {31'd0, frame[i / CPB]});
        checkOutput($sformatf("tx_busy cyc%0d", i), {31'd0, tx_busy}, 32'd1);
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    checkOutput("tx idle after frame", {31'd0, tx}, 32'd1);
    checkOutput("tx_busy after frame", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic waitRxDone(input int base, input string tag);
    for (int k = 0; k < 40 && done_cnt == base; k++) @(negedge clk);
    @(negedge clk);
    checkOutput(tag, done_cnt, base + 1);
  endtask

  task automatic driveRxFrame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = frame[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", {31'd0, tx}, 32'd1);
    checkOutput("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rx_data}, 32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback 0x41
    base_done = done_cnt;
    sendAndCheckFrame(8'h41, 1'b0);
    waitRxDone(base_done, "rx_done 0x41");
    lat = done_cyc - accept_cyc;
    checkOutput("loopback latency window", {31'd0, (lat >= FRAME + 1 && lat <= FRAME + 5)}, 32'd1);
    checkOutput("rx_data 0x41", {24'd0, rx_data}, 32'h41);
    checkOutput("no frame err 0x41", err_cnt, 0);
    repeat (4) @(negedge clk);
    checkOutput("rx_data 0x41 held", {24'd0, rx_data}, 32'h41);

    // Second byte shortly after the first rx_done
    base_done = done_cnt;
    sendAndCheckFrame(8'h42, 1'b0);
    waitRxDone(base_done, "rx_done 0x42");
    checkOutput("rx_data 0x42", {24'd0, rx_data}, 32'h42);

    // tx_start with 0x55 while busy must be dropped
    base_done = done_cnt;
    sendAndCheckFrame(8'h41, 1'b1);
    waitRxDone(base_done, "rx_done 0x41 inject");
    checkOutput("rx_data 0x41 inject", {24'd0, rx_data}, 32'h41);
    repeat (FRAME / 2) @(negedge clk);
    checkOutput("no queued frame busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("no queued frame done", done_cnt, base_done + 1);

    // Framing error then a good frame, driven directly
    loopback = 1'b0;
    rx_drv   = 1'b1;
    repeat (4) @(negedge clk);
    base_done = done_cnt;
    base_err  = err_cnt;
    driveRxFrame(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    checkOutput("frame err pulse", err_cnt, base_err + 1);
    checkOutput("frame err no done", done_cnt, base_done);
    checkOutput("frame err rx_data kept", {24'd0, rx_data}, 32'h41);
    driveRxFrame(8'hA5, 1'b1);
    repeat (CPB) @(negedge clk);
    checkOutput("rx_done 0xA5", done_cnt, base_done + 1);
    checkOutput("rx_data 0xA5", {24'd0, rx_data}, 32'hA5);
    checkOutput("no err 0xA5", err_cnt, base_err + 1);

    // Short low glitch is rejected silently
    base_done = done_cnt;
    base_err  = err_cnt;
    rx_drv = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch no done", done_cnt, base_done);
    checkOutput("glitch no err", err_cnt, base_err);

    // Reset in the middle of a transmitted data bit
    loopback  = 1'b1;
    base_done = done_cnt;
    base_err  = err_cnt;
    applyStimulus(8'hC3);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("busy before reset", {31'd0, tx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset tx", {31'd0, tx}, 32'd1);
    checkOutput("mid-frame reset tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("mid-frame reset rx_data", {24'd0, rx_data}, 32'h00);
    rst = 1'b0;
    repeat (FRAME + 20) @(negedge clk);
    checkOutput("after reset no done", done_cnt, base_done);
    checkOutput("after reset no err", err_cnt, base_err);
    checkOutput("after reset tx idle", {31'd0, tx}, 32'd1);

    checkOutput("done and err never together", {31'd0, both_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
